uart_frame_tx: RTL

Buffered UART transmitter that sits on the same 16× oversampling enable from the baud generator as the UART receiver, forming the transmit half of the SmartHome serial link. It accepts bytes from the control logic through a small FIFO and serialises each one as 8N1, or 8E1 when configured. Frames go out back-to-back with no idle gap while data is queued.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/tx_fifo.sv | 71 +++++++
 rtl/uart_frame_tx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the SmartHome UART transmit path.
//   tx_state_t      - transmitter frame states (PARITY only reached when
//                     UART_TX_PARITY_EN is defined)
//   UART_DATA_W     - payload width of one frame
//   UART_OVERSAMPLE - clken pulses per bit period
//   evenParity()    - even-parity bit for one payload byte
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int UART_DATA_W     = 8;
  localparam int UART_OVERSAMPLE = 16;

  // The even-parity bit makes the total count of ones in data+parity even,
  // which is simply the XOR reduction of the payload.
  function automatic logic evenParity(input logic [UART_DATA_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous byte FIFO in front of the UART transmitter.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset, flushes the buffer
//   wr_en    in   write strobe; accepted only while not full
//   wr_data  in   byte to store
//   rd_en    in   pop strobe; ignored while empty
//   rd_data  out  byte at the head (valid while count != 0)
//   full     out  registered, buffer holds DEPTH entries
//   count    out  registered number of stored entries
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             wrFire, rdFire;

  // A write into a full buffer is rejected even if a pop happens in the
  // same cycle; pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wrFire  = wr_en & ~full_q;
    rdFire  = rd_en & (count_q != '0);
    count_d = count_q;
    unique case ({wrFire, rdFire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (wrFire) wrPtr_q <= wrPtr_q + AW'(1);
      if (rdFire) rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Storage needs no reset: a flush only has to clear the occupancy state.
  always_ff @(posedge clk) begin
    if (wrFire) mem_q[wrPtr_q] <= wr_data;
  end

  assign rd_data = mem_q[rdPtr_q];
  assign full    = full_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: buffered 8N1 UART transmitter driven by the 16x baud enable.
// Define UART_TX_PARITY_EN to compile in an even-parity bit (8E1 frames).
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   clken     in   oversampling enable, OVERSAMPLE pulses per bit
//   data      in   byte to queue
//   wr_en     in   write strobe, taken when not full
//   full      out  FIFO holds FIFO_DEPTH bytes
//   count     out  bytes queued, excluding the one being sent
//   overflow  out  sticky, a write was attempted while full
//   busy      out  frame in progress or bytes queued
//   tx        out  registered serial line, idle high
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clken,
  input  logic [UART_DATA_W-1:0]        data,
  input  logic                          wr_en,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  tx_state_t              state_q, state_d;
  logic [TICK_W-1:0]      tickCnt_q, tickCnt_d;
  logic [2:0]             bitCnt_q, bitCnt_d;
  logic [UART_DATA_W-1:0] shiftReg_q, shiftReg_d;
  logic                   tx_q, tx_d;
  logic                   overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic                        pop;
  logic                        bitDone;
  logic [UART_DATA_W-1:0]      fifoData;
  logic                        fifoFull;
  logic [$clog2(FIFO_DEPTH):0] fifoCount;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (data),
    .rd_en   (pop),
    .rd_data (fifoData),
    .full    (fifoFull),
    .count   (fifoCount)
  );

  // A bit ends on the clk edge that consumes its OVERSAMPLE-th clken pulse.
  assign bitDone = clken && (tickCnt_q == TICK_W'(OVERSAMPLE - 1));

  // Next-state logic. A pop always restarts the frame from START with a
  // fresh tick count, whether it comes from IDLE or straight out of STOP
  // (which is what makes queued frames go out back-to-back). The line
  // level is derived from the next state so tx can be a plain register.
  always_comb begin
    state_d    = state_q;
    tickCnt_d  = tickCnt_q;
    bitCnt_d   = bitCnt_q;
    shiftReg_d = shiftReg_q;
    overflow_d = overflow_q | (wr_en & fifoFull);
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (clken) tickCnt_d = bitDone ? '0 : tickCnt_q + TICK_W'(1);

    unique case (state_q)
      IDLE: begin
        if (fifoCount != '0) pop = 1'b1;
      end
      START: begin
        if (bitDone) state_d = DATA;
      end
      DATA: begin
        if (bitDone) begin
          shiftReg_d = shiftReg_q >> 1;
          if (bitCnt_q == 3'd7) begin
            bitCnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = STOP;
`endif
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bitDone) state_d = STOP;
      end
`endif
      STOP: begin
        if (bitDone) begin
          if (fifoCount != '0) pop = 1'b1;
          else                 state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d    = START;
      shiftReg_d = fifoData;
      tickCnt_d  = '0;
`ifdef UART_TX_PARITY_EN
      parity_d   = evenParity(fifoData);
`endif
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shiftReg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tickCnt_q  <= '0;
      bitCnt_q   <= 3'd0;
      shiftReg_q <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      bitCnt_q   <= bitCnt_d;
      shiftReg_q <= shiftReg_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign full     = fifoFull;
  assign count    = fifoCount;
  assign busy     = (state_q != IDLE) || (fifoCount != '0);

endmodule
